// File: rtl/bsg_gateway_tag_sequencer_pkg.sv
// Shared definitions for the gateway tag sequencer and the ROM generator:
// opcodes, the ROM entry layout and the derived entry width.
`ifndef BSG_GATEWAY_TAG_ENTRY_DECLARE
`define BSG_GATEWAY_TAG_ENTRY_DECLARE(n_mp, els_mp, lw_mp, pw_mp) \
  typedef struct packed {                                        \
    logic [3:0]        opcode;                                   \
    logic [n_mp-1:0]   mask;                                     \
    logic [els_mp-1:0] node_id;                                  \
    logic              data_not_reset;                           \
    logic [lw_mp-1:0]  len;                                      \
    logic [pw_mp-1:0]  payload;                                  \
  } entry_s
`endif

package bsg_gateway_tag_sequencer_pkg;

  typedef enum logic [3:0] {
    op_nop_e      = 4'd0,
    op_send_e     = 4'd1,
    op_wait_e     = 4'd2,
    op_done_e     = 4'd3,
    op_wait_evt_e = 4'd4
  } opcode_e;

  function automatic int rom_data_width(input int num_masters, input int lg_els,
                                        input int lg_width, input int max_payload);
    return 4 + num_masters + lg_els + 1 + lg_width + max_payload;
  endfunction

endpackage

// File: rtl/bsg_gateway_tag_sequencer_if.sv
// ROM fetch port, event input and tag/status outputs of the sequencer.
interface bsg_gateway_tag_sequencer_if #(
  parameter int num_masters_p    = 2,
  parameter int rom_addr_width_p = 32,
  parameter int rom_data_width_p = 36
);
  logic [rom_addr_width_p-1:0] rom_addr_o;
  logic [rom_data_width_p-1:0] rom_data_i;
  logic                        event_i;
  logic [num_masters_p-1:0]    tag_data_o;
  logic [num_masters_p-1:0]    tag_en_o;
  logic                        busy_o;
  logic                        done_o;
  logic                        error_o;

  modport master (
    output rom_addr_o, input rom_data_i, input event_i,
    output tag_data_o, output tag_en_o, output busy_o, output done_o, output error_o
  );

  modport slave (
    input rom_addr_o, output rom_data_i, output event_i,
    input tag_data_o, input tag_en_o, input busy_o, input done_o, input error_o
  );
endinterface

// File: rtl/bsg_gateway_tag_sequencer_serializer.sv
// Shifts one bsg_tag packet out LSB-first: start bit, node_id, data_not_reset,
// len, then the low len bits of the payload.
module bsg_gateway_tag_sequencer_serializer #(
  parameter int lg_els_p            = 10,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 15
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           en_i,
  input  logic                           start_i,
  input  logic [lg_els_p-1:0]            node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           bit_o,
  output logic                           active_o,
  output logic                           last_o
);
  localparam int hdr_lp   = 2 + lg_els_p + lg_width_p;
  localparam int total_lp = hdr_lp + max_payload_width_p;
  localparam int cnt_w_lp = $clog2(total_lp + 1);

  logic [total_lp-1:0] shift_reg;
  logic [cnt_w_lp-1:0] remain_reg;

  // Whole payload is loaded; the remaining-bit count cuts it at len.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_reg  <= '0;
      remain_reg <= '0;
    end else if (en_i) begin
      if (start_i) begin
        shift_reg  <= {payload_i, len_i, data_not_reset_i, node_id_i, 1'b1};
        remain_reg <= cnt_w_lp'(hdr_lp) + cnt_w_lp'(len_i);
      end else if (remain_reg != '0) begin
        shift_reg  <= {1'b0, shift_reg[total_lp-1:1]};
        remain_reg <= remain_reg - cnt_w_lp'(1);
      end
    end
  end

  assign active_o = (remain_reg != '0);
  assign bit_o    = active_o & shift_reg[0];
  assign last_o   = (remain_reg == cnt_w_lp'(1));
endmodule

// File: rtl/bsg_gateway_tag_sequencer.sv
// Plays a tag trace from a combinational boot ROM onto num_masters_p tag lines,
// with timed waits, event waits and sticky done/error reporting.
module bsg_gateway_tag_sequencer
  import bsg_gateway_tag_sequencer_pkg::*;
#(
  parameter int num_masters_p       = 2,
  parameter int lg_els_p            = 10,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 15,
  parameter int rom_addr_width_p    = 32,
  parameter int rom_data_width_p    = rom_data_width(num_masters_p, lg_els_p,
                                                     lg_width_p, max_payload_width_p)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  bsg_gateway_tag_sequencer_if.master bus
);
  localparam logic [2:0] fetch_s = 3'd0;
  localparam logic [2:0] exec_s  = 3'd1;
  localparam logic [2:0] send_s  = 3'd2;
  localparam logic [2:0] wait_s  = 3'd3;
  localparam logic [2:0] evt_s   = 3'd4;
  localparam logic [2:0] done_s  = 3'd5;
  localparam logic [2:0] error_s = 3'd6;

  `BSG_GATEWAY_TAG_ENTRY_DECLARE(num_masters_p, lg_els_p, lg_width_p, max_payload_width_p);

  entry_s                          rom_entry;
  entry_s                          instr_reg;
  logic [2:0]                      state_reg, state_next;
  logic [max_payload_width_p-1:0]  cnt_reg, cnt_next;
  logic [rom_addr_width_p-1:0]     addr_reg;
  logic                            start;
  logic                            ser_bit, ser_active, ser_last;
  logic                            in_send;

  assign rom_entry = bus.rom_data_i;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start      = 1'b0;
    if (en_i) begin
      case (state_reg)
        fetch_s: state_next = exec_s;
        exec_s: begin
          case (instr_reg.opcode)
            op_nop_e: state_next = fetch_s;
            op_send_e: begin
              if (32'(instr_reg.len) > max_payload_width_p) begin
                state_next = error_s;
              end else begin
                state_next = send_s;
                start      = 1'b1;
              end
            end
            op_wait_e: begin
              if (instr_reg.payload == '0) begin
                state_next = fetch_s;
              end else begin
                state_next = wait_s;
                cnt_next   = instr_reg.payload;
              end
            end
            op_done_e:     state_next = done_s;
            op_wait_evt_e: state_next = evt_s;
            default:       state_next = error_s;
          endcase
        end
        send_s: if (ser_last) state_next = fetch_s;
        wait_s: begin
          if (cnt_reg == max_payload_width_p'(1)) state_next = fetch_s;
          else                                    cnt_next   = cnt_reg - max_payload_width_p'(1);
        end
        evt_s: if (bus.event_i) state_next = fetch_s;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= fetch_s;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (en_i && state_reg == fetch_s) begin
        instr_reg <= rom_entry;
        addr_reg  <= addr_reg + rom_addr_width_p'(1);
      end
    end
  end

  bsg_gateway_tag_sequencer_serializer #(
    .lg_els_p           (lg_els_p),
    .lg_width_p         (lg_width_p),
    .max_payload_width_p(max_payload_width_p)
  ) serializer (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .en_i            (en_i),
    .start_i         (start),
    .node_id_i       (instr_reg.node_id),
    .data_not_reset_i(instr_reg.data_not_reset),
    .len_i           (instr_reg.len),
    .payload_i       (instr_reg.payload),
    .bit_o           (ser_bit),
    .active_o        (ser_active),
    .last_o          (ser_last)
  );

  assign in_send = (state_reg == send_s) & ser_active;

  // Unmasked masters stay fully quiet, including their enable.
  for (genvar gi = 0; gi < num_masters_p; gi++) begin : g_master
    assign bus.tag_en_o[gi]   = in_send & instr_reg.mask[gi];
    assign bus.tag_data_o[gi] = in_send & instr_reg.mask[gi] & ser_bit;
  end

  assign bus.rom_addr_o = addr_reg;
  assign bus.busy_o     = (state_reg == send_s) | (state_reg == wait_s) | (state_reg == evt_s);
  assign bus.done_o     = (state_reg == done_s) | (state_reg == error_s);
  assign bus.error_o    = (state_reg == error_s);
endmodule

// File: tb/tb_bsg_gateway_tag_sequencer.sv
// Directed bench for the tag sequencer: a 15-bit-payload instance plus a
// 12-bit-payload instance for the oversized-len error case.
module tb_bsg_gateway_tag_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic evt = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [35:0] rom   [16];
  logic [32:0] rom12 [16];

  always #5 clk = ~clk;

  bsg_gateway_tag_sequencer_if #(.num_masters_p(2), .rom_addr_width_p(32), .rom_data_width_p(36)) bus ();
  bsg_gateway_tag_sequencer_if #(.num_masters_p(2), .rom_addr_width_p(32), .rom_data_width_p(33)) bus12 ();

  assign bus.rom_data_i   = rom[bus.rom_addr_o[3:0]];
  assign bus.event_i      = evt;
  assign bus12.rom_data_i = rom12[bus12.rom_addr_o[3:0]];
  assign bus12.event_i    = evt;

  bsg_gateway_tag_sequencer #(.max_payload_width_p(15)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .bus(bus)
  );

  bsg_gateway_tag_sequencer #(.max_payload_width_p(12)) dut12 (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .bus(bus12)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [3:0] op, input logic [1:0] mask,
                                     input logic [9:0] node, input logic dnr,
                                     input logic [3:0] len, input logic [14:0] pay);
    return {op, mask, node, dnr, len, pay};
  endfunction

  function automatic logic [32:0] mk12(input logic [3:0] op, input logic [1:0] mask,
                                       input logic [9:0] node, input logic dnr,
                                       input logic [3:0] len, input logic [11:0] pay);
    return {op, mask, node, dnr, len, pay};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) begin
      rom[i]   = mk(4'd3, 2'b00, 10'h0, 1'b0, 4'd0, 15'h0);
      rom12[i] = mk12(4'd3, 2'b00, 10'h0, 1'b0, 4'd0, 12'h0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    evt   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Samples nbits of a packet, optionally stalling en for 5 cycles at bit 8.
  task automatic send_stream(input logic [1:0] mask, input int nbits, input bit pause,
                             output logic [31:0] s0, output logic [31:0] s1,
                             output int en_bad, output int busy_bad);
    logic [35:0] held;
    s0 = '0;
    s1 = '0;
    en_bad = 0;
    busy_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      if (pause && i == 8) begin
        en   = 1'b0;
        held = {bus.tag_en_o, bus.tag_data_o, bus.rom_addr_o};
        for (int k = 0; k < 5; k++) begin
          step();
          check("send_pause_hold", {bus.tag_en_o, bus.tag_data_o, bus.rom_addr_o}, held);
        end
        en = 1'b1;
      end
      s0[i] = bus.tag_data_o[0];
      s1[i] = bus.tag_data_o[1];
      if (bus.tag_en_o !== mask) en_bad++;
      if (bus.busy_o !== 1'b1) busy_bad++;
      step();
    end
  endtask

  task automatic run_send_a(input string name, input bit pause, input bit mid_reset);
    logic [31:0] s0, s1;
    int          en_bad, busy_bad;
    clear_rom();
    rom[0] = mk(4'd1, 2'b01, 10'h005, 1'b1, 4'd4, 15'h000A);
    do_reset();
    step();
    step();
    if (mid_reset) begin
      for (int k = 0; k < 5; k++) step();
      rst_n = 1'b0;
      #1;
      check({name, "_rst_lines"}, {bus.tag_en_o, bus.tag_data_o, bus.busy_o}, 5'b0);
      check({name, "_rst_addr"}, bus.rom_addr_o, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      step();
    end
    send_stream(2'b01, 20, pause, s0, s1, en_bad, busy_bad);
    // start 1, node 0x005, dnr 1, len 4, payload 0xA, LSB first
    check({name, "_m0"}, s0, 32'h000A480B);
    check({name, "_m1"}, s1, 32'h0);
    check({name, "_en"}, en_bad, 0);
    check({name, "_busy"}, busy_bad, 0);
    check({name, "_idle_after"}, bus.tag_en_o, 2'b00);
    step();
    step();
    check({name, "_done"}, {bus.done_o, bus.error_o, bus.rom_addr_o}, {2'b10, 32'd2});
    $display("test %s complete", name);
  endtask

  initial begin
    logic [31:0] s0, s1;
    int          en_bad, busy_bad, n, lines_seen;

    // Reset state, then {NOP, DONE}.
    clear_rom();
    rom[0] = mk(4'd0, 2'b11, 10'h3FF, 1'b1, 4'd4, 15'h1);
    rst_n = 1'b0;
    en = 1'b1;
    step();
    step();
    check("reset_addr", bus.rom_addr_o, 32'd0);
    check("reset_outs", {bus.tag_data_o, bus.tag_en_o, bus.busy_o, bus.done_o, bus.error_o}, 7'b0);
    rst_n = 1'b1;
    lines_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      lines_seen += int'(bus.tag_en_o != 2'b00);
    end
    check("nop_not_done_yet", bus.done_o, 1'b0);
    step();
    lines_seen += int'(bus.tag_en_o != 2'b00);
    check("nop_done", bus.done_o, 1'b1);
    check("nop_addr", bus.rom_addr_o, 32'd2);
    check("nop_no_lines", lines_seen, 0);
    $display("test nop complete");

    run_send_a("send_a", 1'b0, 1'b0);
    run_send_a("send_a_pause", 1'b1, 1'b0);
    run_send_a("send_a_midreset", 1'b0, 1'b1);

    // Both masters, len 0: 16-bit header only; high payload bits ignored.
    clear_rom();
    rom[0] = mk(4'd1, 2'b11, 10'h3C5, 1'b0, 4'd0, 15'h7FFF);
    do_reset();
    step();
    step();
    send_stream(2'b11, 16, 1'b0, s0, s1, en_bad, busy_bad);
    check("hdr_m0", s0, 32'h0000078B);
    check("hdr_m1", s1, 32'h0000078B);
    check("hdr_en", en_bad, 0);
    check("hdr_fetch_now", {bus.tag_en_o, bus.busy_o, bus.rom_addr_o}, {3'b000, 32'd1});
    step();
    check("hdr_fetched", bus.rom_addr_o, 32'd2);
    step();
    check("hdr_done", bus.done_o, 1'b1);
    $display("test header complete");

    // WAIT 3 (with an en stall), WAIT_EVT low 7 cycles, WAIT_EVT already high.
    clear_rom();
    rom[0] = mk(4'd2, 2'b00, 10'h0, 1'b0, 4'd0, 15'd3);
    rom[1] = mk(4'd4, 2'b00, 10'h0, 1'b0, 4'd0, 15'd0);
    rom[2] = mk(4'd4, 2'b00, 10'h0, 1'b0, 4'd0, 15'd0);
    do_reset();
    step();
    step();
    n = 0;
    while (bus.busy_o && n < 20) begin
      n++;
      if (n == 2) begin
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          check("wait_pause_hold", {bus.busy_o, bus.rom_addr_o}, {1'b1, 32'd1});
        end
        en = 1'b1;
      end
      step();
    end
    check("wait_cycles", n, 3);
    check("wait_exit_addr", bus.rom_addr_o, 32'd1);
    step();
    step();
    n = 0;
    for (int k = 0; k < 7; k++) begin
      if (bus.busy_o !== 1'b1) n++;
      step();
    end
    check("evt_low_busy", n, 0);
    evt = 1'b1;
    step();
    check("evt_exit", {bus.busy_o, bus.rom_addr_o}, {1'b0, 32'd2});
    step();
    step();
    check("evt_high_entry_busy", bus.busy_o, 1'b1);
    step();
    check("evt_high_one_cycle", bus.busy_o, 1'b0);
    evt = 1'b0;
    step();
    step();
    check("evt_done", {bus.done_o, bus.rom_addr_o}, {1'b1, 32'd4});
    $display("test wait_evt complete");

    // Illegal opcode on main instance; len 15 > 12 on the small instance.
    clear_rom();
    rom[0]   = mk(4'hF, 2'b11, 10'h155, 1'b1, 4'd4, 15'h000F);
    rom12[0] = mk12(4'd1, 2'b11, 10'h155, 1'b1, 4'd15, 12'hFFF);
    do_reset();
    lines_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      lines_seen += int'({bus.tag_en_o, bus.tag_data_o, bus12.tag_en_o, bus12.tag_data_o} != 8'h0);
    end
    check("illegal_flags", {bus.error_o, bus.done_o, bus.busy_o}, 3'b110);
    check("illegal_addr", bus.rom_addr_o, 32'd1);
    check("len_err_flags", {bus12.error_o, bus12.done_o, bus12.busy_o}, 3'b110);
    check("len_err_addr", bus12.rom_addr_o, 32'd1);
    check("error_no_lines", lines_seen, 0);
    $display("test error complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bsg_gateway_tag_sequencer.md
Name: bsg_gateway_tag_sequencer

Overview:
- Parametrised successor to the gateway's single-stream tag trace player.
- Fetches tag-trace instructions from a combinational boot ROM and serialises bsg_tag packets onto N independent master lines, each with its own enable.
- Adds timed waits, wait-for-external-event, and done/error reporting; done_o freezes the tag clock.
- Sits in the gateway chip between the tag boot ROM and the tag pads / local tag masters.

Parameters:
- num_masters_p, 2, number of tag master lines driven.
- lg_els_p, 10, width of the tag client node-id field.
- lg_width_p, 4, width of the payload-length field.
- max_payload_width_p, 15, maximum payload bits per packet.
- rom_addr_width_p, 32, width of the ROM address.
- rom_data_width_p, 4+num_masters_p+lg_els_p+1+lg_width_p+max_payload_width_p, width of one ROM entry (derived; do not override).

Ports:
- clk_i  in  1  tag clock.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  advance enable; deasserted means all state holds.
- rom_addr_o  out  rom_addr_width_p  ROM address (registered).
- rom_data_i  in  rom_data_width_p  ROM entry, valid combinationally from rom_addr_o.
- event_i  in  1  external event for the WAIT_EVT opcode; level-sensitive.
- tag_data_o  out  num_masters_p  serial tag data, one bit per master.
- tag_en_o  out  num_masters_p  per-master packet-active enable.
- busy_o  out  1  high while a packet is being sent or a wait is in progress.
- done_o  out  1  sticky; the trace has finished.
- error_o  out  1  sticky; an illegal instruction was fetched.

Behaviour:
- Entry fields, MSB to LSB: opcode[3:0], mask[num_masters_p], node_id[lg_els_p], data_not_reset[1], len[lg_width_p], payload[max_payload_width_p].
- Opcodes:
  - 0 NOP.
  - 1 SEND.
  - 2 WAIT: cycles = payload.
  - 3 DONE.
  - 4 WAIT_EVT.
  - 5-15 illegal.
- Reset (async assert, synchronous-safe release):
  - state=FETCH, rom_addr_o=0.
  - tag_data_o=0, tag_en_o=0, busy_o=0, done_o=0, error_o=0.
- en_i=0: no state, counter or address change; outputs hold their current values.
- FETCH: latch rom_data_i into instr_r, then rom_addr_o<=rom_addr_o+1 and go to EXEC. rom_addr_o wraps modulo 2^rom_addr_width_p with no flag.
- EXEC (1 cycle):
  - NOP: go to FETCH.
  - SEND: if len>max_payload_width_p, go to ERROR. Otherwise go to SEND with bit_cnt=0.
  - WAIT: if payload==0, go to FETCH. Otherwise go to WAIT with cnt=payload.
  - DONE: go to DONE.
  - WAIT_EVT: go to EVT.
  - Illegal opcode: go to ERROR.
- SEND:
  - Serial stream, LSB-first per field: 1 start bit (1), node_id, data_not_reset, len, then payload[len-1:0].
  - Total bits T = 2+lg_els_p+lg_width_p+len; one bit per enabled cycle.
  - For each master i: tag_en_o[i]=mask[i]; tag_data_o[i]=mask[i] & current bit. Unmasked masters drive 0.
  - After bit T-1 go to FETCH. tag_en_o and tag_data_o are 0 outside SEND.
  - mask==0 is legal: T cycles elapse with no lines active.
- WAIT: decrement cnt each enabled cycle; when cnt==1 go to FETCH. A wait of N occupies exactly N cycles in WAIT.
- EVT:
  - Stay while event_i==0.
  - Go to FETCH the first enabled cycle that samples event_i==1.
  - If event_i is already high on entry, exactly 1 cycle is spent in EVT.
- DONE: terminal. done_o=1; rom_addr_o frozen.
- ERROR: terminal. error_o=1, done_o=1; all outputs quiescent.
- busy_o=1 in SEND, WAIT and EVT.
- Reset mid-packet: lines drop to 0 immediately (async); the trace restarts from address 0.

Decomposition:
- bsg_tag_pkg: opcode enum, entry struct (declare macro parameterised by the widths), and the derived rom_data_width formula. Both this block and the ROM generator script use it.
- One sub-module, bsg_tag_packet_serializer:
  - Inputs: node_id, data_not_reset, len, payload, a start pulse, en.
  - Outputs: bit_o, active_o, last_o.
  - The sequencer owns the FSM, counters and mask fan-out.

Test Plan:
- Reset and NOP: ROM = {NOP, DONE} -> rom_addr_o reaches 2; done_o=1 on the 5th enabled cycle after reset release; tag_en_o=0 throughout.
- SEND with mask=2'b01, node_id=10'h005, dnr=1, len=4, payload=4'hA -> master0 emits 1,1010000000,1,0010,0101 over 20 cycles with tag_en_o=2'b01; master1 stays 0.
- SEND with mask=2'b11 and len=0 -> both lines emit an identical 16-bit header; next FETCH follows immediately.
- WAIT payload=3 then event: WAIT_EVT with event_i held low for 7 cycles, then high -> exactly 3 WAIT cycles; EVT exits on the cycle event_i rises; busy_o high throughout.
- Illegal opcode 4'hF, and separately SEND with len=15 when max_payload_width_p=12 -> error_o=1, done_o=1, no line toggles.
- en_i deasserted for 5 cycles mid-SEND and mid-WAIT -> outputs hold, bit stream unaltered; reset_n_i pulsed mid-SEND -> immediate zero outputs and a restart at address 0.
